sym_shift_buffer: RTL and testbench
===================================

Name: sym_shift_buffer

Overview:
- Multi-channel symbol shift buffer; parametrised successor of the fixed 4-channel, 18-bit shift-by-3 stage.
- Each channel holds up to DEPTH symbols of SYM_W bits, packed LSB-first.
- Symbols are presented show-ahead at the channel output and consumed one per pop; the remaining symbols shift down and zeros fill from the top.
- Sits between the symbol packer (which loads whole words) and the per-channel symbol consumers; it replaces the combinational shifter with a registered, handshaked buffer.

Parameters:
- CHANNELS, 4, number of independent channels.
- SYM_W, 3, bits per symbol.
- DEPTH, 6, symbols per channel word; word width = DEPTH*SYM_W (18 at defaults).
- Derived localparam CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  CHANNELS  per-channel load request.
- load_ready  out  CHANNELS  per-channel load accept.
- load_data  in  CHANNELS*DEPTH*SYM_W  per-channel word; channel c at slice [c*DEPTH*SYM_W +: DEPTH*SYM_W]; symbol 0 in the LSBs.
- load_count  in  CHANNELS*CNT_W  number of valid symbols in load_data.
- pop  in  CHANNELS  consume the current symbol.
- sym_valid  out  CHANNELS  channel holds at least 1 symbol.
- sym_data  out  CHANNELS*SYM_W  current (lowest) symbol of each channel.
- buf_snapshot  out  CHANNELS*DEPTH*SYM_W  full buffer register of each channel.
- level  out  CHANNELS*CNT_W  symbols held per channel.
- err  out  CHANNELS  sticky error flags; present only with SYM_SHIFT_ERR_EN.

Behaviour:
- Reset: while rst=1 at a clock edge, all buffers, levels and err flags clear to 0. Consequently sym_valid=0, sym_data=0, buf_snapshot=0, level=0, load_ready=all 1. Reset overrides any load or pop in the same cycle.
- Channels are fully independent; there is no arbitration and no cross-channel interaction.
- Per-channel state is level: 0 = EMPTY, 1..DEPTH = ACTIVE.
- Outputs are driven directly from registers, with no combinational path from inputs:
  - sym_data = buf[SYM_W-1:0]
  - sym_valid = (level != 0)
  - buf_snapshot = buf
- load_ready = (level==0) || (level==1 && pop). This is combinational from pop and allows back-to-back refill.
- Load (load_valid && load_ready):
  - Next cycle: buf <= load_data with symbol slots at index >= load_count forced to 0.
  - Next cycle: level <= min(load_count, DEPTH). A load_count above DEPTH is clamped to DEPTH.
  - load_count==0: handshake completes, buf and level unchanged.
- Pop (pop && sym_valid, no load the same cycle):
  - buf <= {SYM_W zeros, buf[DEPTH*SYM_W-1:SYM_W]}, i.e. logical shift right by SYM_W.
  - level <= level-1.
- Pop while EMPTY is ignored: no state change.
- Pop and load in the same cycle at level==1: the popped symbol is consumed and the load takes effect. The result equals the loaded word, with no stale symbol and no extra shift.
- load_valid while not ready: ignored, no change; the upstream holds the data.
- Latency:
  - Load to sym_valid: 1 cycle.
  - Pop to next symbol on sym_data: 1 cycle.
  - Throughput: 1 symbol per channel per cycle.
- Full drain: DEPTH pops leave buf=0 and level=0.

Optional Feature:
- Macro SYM_SHIFT_ERR_EN.
- Defined:
  - The err port exists.
  - err[c] sets on pop while channel c is EMPTY, or on load_valid while load_ready=0.
  - err[c] stays set until rst.
  - err has no effect on data path behaviour.
- Undefined: the err port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with load_valid=all 1 and pop=all 1 -> after release: level=0, sym_valid=0, buf_snapshot=0, load_ready=4'b1111.
- Load and drain (defaults): load ch0 data 18'o654321 with count 6:
  - Next cycle: sym_data ch0=1, level=6.
  - pop -> sym_data=2, buf_snapshot=18'o065432, level=5.
  - 5 more pops -> level=0, buf=0.
- Partial load: load ch2 data 18'o777777 with count 2 -> buf_snapshot ch2=18'o000077, level=2; load_ready=0 until level==1 with pop asserted.
- Refill overlap: ch1 at level 1 holding symbol 5; pop together with a load of 18'o000123, count 3 -> next cycle sym_data=3, level=3.
- Boundaries:
  - pop on empty ch3 -> no state change.
  - load_count 7 -> level clamps to 6.
  - load_count 0 -> level unchanged.
  - With SYM_SHIFT_ERR_EN: pop on empty ch3 sets err[3]; err[3] stays 1 until rst.
- Channel independence: simultaneous loads on all 4 channels with different counts, then staggered pops -> each channel's level and sym_data track only its own handshakes.

Source files
------------

// File: rtl/sym_shift_buffer.sv
// Multi-channel show-ahead symbol shift buffer: each channel loads a word of DEPTH symbols
// and pops them LSB-first. Optional sticky per-channel error flags are built with SYM_SHIFT_ERR_EN.
module sym_shift_buffer #(
    parameter int CHANNELS = 4,
    parameter int SYM_W    = 3,
    parameter int DEPTH    = 6,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int WORD_W  = DEPTH * SYM_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          load_valid,
    output logic [CHANNELS-1:0]          load_ready,
    input  logic [CHANNELS*WORD_W-1:0]   load_data,
    input  logic [CHANNELS*CNT_W-1:0]    load_count,
    input  logic [CHANNELS-1:0]          pop,
    output logic [CHANNELS-1:0]          sym_valid,
    output logic [CHANNELS*SYM_W-1:0]    sym_data,
    output logic [CHANNELS*WORD_W-1:0]   buf_snapshot,
    output logic [CHANNELS*CNT_W-1:0]    level
`ifdef SYM_SHIFT_ERR_EN
    ,
    output logic [CHANNELS-1:0]          err
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WORD_W-1:0] buf_q;
        logic [CNT_W-1:0]  level_q;
        logic [WORD_W-1:0] data_in;
        logic [WORD_W-1:0] data_masked;
        logic [CNT_W-1:0]  cnt_in;
        logic [CNT_W-1:0]  cnt_clamped;
        logic              ready;
        logic              do_load;
        logic              do_pop;

        assign data_in = load_data[c*WORD_W +: WORD_W];
        assign cnt_in  = load_count[c*CNT_W +: CNT_W];

        // Ready also when the last symbol leaves this cycle, so a refill can overlap the final pop.
        always_comb begin
            ready = (level_q == '0) || ((level_q == ONE_C) && pop[c]);
        end

        always_comb begin
            cnt_clamped = (cnt_in > DEPTH_C) ? DEPTH_C : cnt_in;
        end

        always_comb begin
            data_masked = '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (CNT_W'(s) < cnt_clamped) begin
                    data_masked[s*SYM_W +: SYM_W] = data_in[s*SYM_W +: SYM_W];
                end
            end
        end

        // A zero-count load completes the handshake but leaves state alone; a concurrent pop still applies.
        always_comb begin
            do_load = load_valid[c] && ready && (cnt_in != '0);
            do_pop  = pop[c] && (level_q != '0);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                buf_q   <= '0;
                level_q <= '0;
            end else if (do_load) begin
                buf_q   <= data_masked;
                level_q <= cnt_clamped;
            end else if (do_pop) begin
                buf_q   <= {{SYM_W{1'b0}}, buf_q[WORD_W-1:SYM_W]};
                level_q <= level_q - ONE_C;
            end
        end

        assign load_ready[c]                        = ready;
        assign sym_valid[c]                         = (level_q != '0);
        assign sym_data[c*SYM_W +: SYM_W]           = buf_q[SYM_W-1:0];
        assign buf_snapshot[c*WORD_W +: WORD_W]     = buf_q;
        assign level[c*CNT_W +: CNT_W]              = level_q;

`ifdef SYM_SHIFT_ERR_EN
        logic err_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if ((pop[c] && (level_q == '0)) || (load_valid[c] && !ready)) begin
                err_q <= 1'b1;
            end
        end

        assign err[c] = err_q;
`endif
    end

endmodule

// File: tb/tb_sym_shift_buffer.sv
// Scoreboard bench for sym_shift_buffer at default parameters: stimulus queues expected
// per-channel values tagged with a cycle number; a negedge monitor pops and compares them.
module tb_sym_shift_buffer;

  localparam int CH = 4;
  localparam int SW = 3;
  localparam int D  = 6;
  localparam int CW = 3;
  localparam int WW = D * SW;

  localparam int K_LEVEL = 0;
  localparam int K_VALID = 1;
  localparam int K_DATA  = 2;
  localparam int K_SNAP  = 3;
  localparam int K_READY = 4;
  localparam int K_ERR   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CH-1:0]        load_valid;
  logic [CH-1:0]        load_ready;
  logic [CH*WW-1:0]     load_data;
  logic [CH*CW-1:0]     load_count;
  logic [CH-1:0]        pop;
  logic [CH-1:0]        sym_valid;
  logic [CH*SW-1:0]     sym_data;
  logic [CH*WW-1:0]     buf_snapshot;
  logic [CH*CW-1:0]     level;
`ifdef SYM_SHIFT_ERR_EN
  logic [CH-1:0]        err;
`endif

  sym_shift_buffer #(
    .CHANNELS(CH),
    .SYM_W   (SW),
    .DEPTH   (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_count  (load_count),
    .pop         (pop),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .buf_snapshot(buf_snapshot),
    .level       (level)
`ifdef SYM_SHIFT_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       name;
    int          ch;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [31:0] actual(int ch, int kind);
    case (kind)
      K_LEVEL: return 32'(level[ch*CW +: CW]);
      K_VALID: return 32'(sym_valid[ch]);
      K_DATA:  return 32'(sym_data[ch*SW +: SW]);
      K_SNAP:  return 32'(buf_snapshot[ch*WW +: WW]);
      K_READY: return 32'(load_ready[ch]);
`ifdef SYM_SHIFT_ERR_EN
      K_ERR:   return 32'(err[ch]);
`endif
      default: return 32'hdeadbeef;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t        e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.ch, e.kind);
      checks++;
      if (e.at == cyc && a === e.exp) begin
        passed++;
      end else begin
        $display("FAIL %s ch%0d cycle %0d: got %0o, expected %0o (due cycle %0d)",
                 e.name, e.ch, cyc, a, e.exp, e.at);
      end
    end
  end

  task automatic ex(int at, string n, int ch, int kind, logic [31:0] v);
    exp_t e;
    e.at = at; e.name = n; e.ch = ch; e.kind = kind; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic st(int at, string tag, int ch, logic [31:0] lvl, logic [17:0] snap);
    logic [2:0] low;
    low = snap[2:0];
    ex(at, {tag, "_level"}, ch, K_LEVEL, lvl);
    ex(at, {tag, "_valid"}, ch, K_VALID, 32'(lvl != 0));
    ex(at, {tag, "_data"},  ch, K_DATA,  32'(low));
    ex(at, {tag, "_snap"},  ch, K_SNAP,  32'(snap));
  endtask

  task automatic er(int at, string tag, int ch, logic v);
`ifdef SYM_SHIFT_ERR_EN
    ex(at, {tag, "_err"}, ch, K_ERR, 32'(v));
`endif
  endtask

  task automatic clr();
    load_valid = '0;
    pop        = '0;
    load_data  = '0;
    load_count = '0;
  endtask

  task automatic ld(int ch, logic [17:0] d, logic [2:0] n);
    load_valid[ch]          = 1'b1;
    load_data[ch*WW +: WW]  = d;
    load_count[ch*CW +: CW] = n;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clr();
  endtask

  int cc;

  initial begin
    rst        = 1'b1;
    load_valid = '1;
    pop        = '1;
    load_data  = '1;
    load_count = {CH{3'd6}};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    cc = cyc;
    #1;
    checks++;
    if (level === '0) passed++;
    else $display("FAIL direct reset level: got %0o", level);
    checks++;
    if (sym_valid === '0) passed++;
    else $display("FAIL direct reset sym_valid: got %b", sym_valid);
    checks++;
    if (buf_snapshot === '0) passed++;
    else $display("FAIL direct reset buf_snapshot: got %0o", buf_snapshot);
    checks++;
    if (load_ready === 4'b1111) passed++;
    else $display("FAIL direct reset load_ready: got %b", load_ready);
    for (int c = 0; c < CH; c++) begin
      st(cc, "reset", c, 0, 18'o0);
      ex(cc, "reset_ready", c, K_READY, 1);
      er(cc, "reset", c, 1'b0);
    end

    // T0: full load ch0, partial ch2, single-symbol ch1, pop on empty ch3
    next(); cc = cyc;
    ld(0, 18'o654321, 3'd6);
    ld(2, 18'o777777, 3'd2);
    ld(1, 18'o000005, 3'd1);
    pop[3] = 1'b1;
    ex(cc, "t0_ready", 0, K_READY, 1);
    st(cc + 1, "t0_full", 0, 6, 18'o654321);
    st(cc + 1, "t0_partial", 2, 2, 18'o000077);
    st(cc + 1, "t0_single", 1, 1, 18'o000005);
    st(cc + 1, "t0_pop_empty", 3, 0, 18'o0);
    er(cc + 1, "t0_pop_empty", 3, 1'b1);
    er(cc + 1, "t0_clean", 0, 1'b0);

    // T1: pop ch0; ch2 load while not ready is ignored
    next(); cc = cyc;
    checks++;
    if (sym_data[0 +: SW] === 3'd1) passed++;
    else $display("FAIL direct t0 sym_data ch0: got %0o", sym_data[0 +: SW]);
    checks++;
    if (level[0 +: CW] === 3'd6) passed++;
    else $display("FAIL direct t0 level ch0: got %0d", level[0 +: CW]);
    checks++;
    if (load_ready[2] === 1'b0) passed++;
    else $display("FAIL direct t0 load_ready ch2: got %b", load_ready[2]);
    pop[0] = 1'b1;
    ld(2, 18'o111111, 3'd6);
    ex(cc, "t1_notready", 2, K_READY, 0);
    st(cc + 1, "t1_pop1", 0, 5, 18'o065432);
    st(cc + 1, "t1_ignored", 2, 2, 18'o000077);
    er(cc + 1, "t1_load_notready", 2, 1'b1);

    // T2: refill overlap on ch1, pop ch2 down to 1
    next(); cc = cyc;
    pop[0] = 1'b1;
    pop[1] = 1'b1;
    pop[2] = 1'b1;
    ld(1, 18'o000123, 3'd3);
    ex(cc, "t2_refill_ready", 1, K_READY, 1);
    ex(cc, "t2_lvl2_pop_ready", 2, K_READY, 0);
    st(cc + 1, "t2_pop2", 0, 4, 18'o006543);
    st(cc + 1, "t2_refill", 1, 3, 18'o000123);
    st(cc + 1, "t2_pop", 2, 1, 18'o000007);

    next(); cc = cyc;
    pop[0] = 1'b1;
    ex(cc, "t3_lvl1_nopop_ready", 2, K_READY, 0);
    st(cc + 1, "t3_pop3", 0, 3, 18'o000654);

    // T4: ch2 refill with count 7 clamps to DEPTH
    next(); cc = cyc;
    pop[0] = 1'b1;
    pop[2] = 1'b1;
    ld(2, 18'o765432, 3'd7);
    ex(cc, "t4_ready", 2, K_READY, 1);
    st(cc + 1, "t4_pop4", 0, 2, 18'o000065);
    st(cc + 1, "t4_clamp", 2, 6, 18'o765432);

    next(); cc = cyc;
    pop[0] = 1'b1;
    st(cc + 1, "t5_pop5", 0, 1, 18'o000006);

    next(); cc = cyc;
    pop[0] = 1'b1;
    st(cc + 1, "t6_drained", 0, 0, 18'o0);
    ex(cc + 1, "t6_ready", 0, K_READY, 1);

    // T7: zero-count loads leave state unchanged
    next(); cc = cyc;
    ld(3, 18'o777777, 3'd0);
    ld(0, 18'o000777, 3'd0);
    ex(cc, "t7_ready", 3, K_READY, 1);
    st(cc + 1, "t7_cnt0", 3, 0, 18'o0);
    st(cc + 1, "t7_cnt0", 0, 0, 18'o0);
    st(cc + 1, "t7_hold", 1, 3, 18'o000123);
    er(cc + 1, "t7_sticky", 3, 1'b1);
    er(cc + 1, "t7_sticky", 2, 1'b1);
    er(cc + 1, "t7_clean", 0, 1'b0);
    er(cc + 1, "t7_clean", 1, 1'b0);

    // T8: reset mid-run
    next(); cc = cyc;
    rst = 1'b1;
    for (int c = 0; c < CH; c++) begin
      st(cc + 1, "t8_rst", c, 0, 18'o0);
      er(cc + 1, "t8_rst", c, 1'b0);
    end

    // T9: simultaneous loads with different counts
    next(); cc = cyc;
    rst = 1'b0;
    ld(0, 18'o123456, 3'd4);
    ld(1, 18'o123456, 3'd1);
    ld(2, 18'o123456, 3'd6);
    ld(3, 18'o123456, 3'd3);
    st(cc + 1, "t9_ld", 0, 4, 18'o003456);
    st(cc + 1, "t9_ld", 1, 1, 18'o000006);
    st(cc + 1, "t9_ld", 2, 6, 18'o123456);
    st(cc + 1, "t9_ld", 3, 3, 18'o000456);

    next(); cc = cyc;
    pop[0] = 1'b1;
    st(cc + 1, "t10", 0, 3, 18'o000345);
    st(cc + 1, "t10", 1, 1, 18'o000006);
    st(cc + 1, "t10", 2, 6, 18'o123456);
    st(cc + 1, "t10", 3, 3, 18'o000456);

    next(); cc = cyc;
    pop[1] = 1'b1;
    pop[3] = 1'b1;
    st(cc + 1, "t11", 0, 3, 18'o000345);
    st(cc + 1, "t11", 1, 0, 18'o0);
    st(cc + 1, "t11", 3, 2, 18'o000045);

    next(); cc = cyc;
    pop[2] = 1'b1;
    st(cc + 1, "t12", 2, 5, 18'o012345);
    st(cc + 1, "t12", 0, 3, 18'o000345);
    st(cc + 1, "t12", 3, 2, 18'o000045);
    st(cc + 1, "t12", 1, 0, 18'o0);

    next();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s ch%0d: never compared, expected %0o", e.name, e.ch, e.exp);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
